temp_alarm_filter: RTL and testbench

Downstream stage of the temperature-range indicator. It consumes the 1-bit in-range indicator and qualifies it with a persistence filter: the indicator must hold for a set number of consecutive sample strobes before `warn` asserts, and must drop for a set number of strobes before `warn` releases. It also drives a sticky `alarm` flag that clears only on operator acknowledge, and a saturating count of warning episodes for the display stage.

---
 rtl/temp_alarm_filter_if.sv | 13 +
 rtl/temp_alarm_filter.sv | 111 +++++++++++
 tb/tb_temp_alarm_filter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/temp_alarm_filter_if.sv
// Sample/acknowledge inputs and filtered alarm outputs of the temperature alarm filter.
// The master modport drives the samples; the slave modport is the filter itself.
interface temp_alarm_filter_if;
    logic       sample_en;
    logic       ind;
    logic       ack;
    logic       warn;
    logic       alarm;
    logic [7:0] event_cnt;

    modport master (output sample_en, ind, ack, input warn, alarm, event_cnt);
    modport slave  (input sample_en, ind, ack, output warn, alarm, event_cnt);
endinterface

// File: rtl/temp_alarm_filter.sv
// Persistence filter on the in-range indicator: debounced warn, sticky alarm
// cleared by operator ack while idle, and a saturating count of warn episodes.
module temp_alarm_filter #(
    parameter int ON_CNT  = 4,
    parameter int OFF_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    temp_alarm_filter_if.slave   bus
);

    if (ON_CNT < 2 || ON_CNT > 15 || OFF_CNT < 2 || OFF_CNT > 15) begin : g_param_chk
        $error("temp_alarm_filter: ON_CNT/OFF_CNT must be within 2..15");
    end

    localparam logic [3:0] ON_C  = 4'(ON_CNT);
    localparam logic [3:0] OFF_C = 4'(OFF_CNT);

    typedef enum logic [1:0] {IDLE, PEND_ON, ACTIVE, PEND_OFF} state_e;

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       warn_q, warn_d;
    logic       alarm_q, alarm_d;
    logic [7:0] cnt_q, cnt_d;
    logic       new_ep;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        new_ep  = 1'b0;
        if (bus.sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ind) begin
                        state_d = PEND_ON;
                        run_d   = 4'd1;
                    end
                end
                PEND_ON: begin
                    if (!bus.ind) begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end else if (run_q + 4'd1 == ON_C) begin
                        state_d = ACTIVE;
                        run_d   = 4'd0;
                        new_ep  = 1'b1;
                    end else begin
                        run_d   = run_q + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (!bus.ind) begin
                        state_d = PEND_OFF;
                        run_d   = 4'd1;
                    end
                end
                PEND_OFF: begin
                    // A high sample here cancels the release; same episode continues.
                    if (bus.ind) begin
                        state_d = ACTIVE;
                        run_d   = 4'd0;
                    end else if (run_q + 4'd1 == OFF_C) begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end else begin
                        run_d   = run_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end

        warn_d = (state_d == ACTIVE) || (state_d == PEND_OFF);

        // Set beats clear; ack only counts once the registered state is back to IDLE.
        alarm_d = alarm_q;
        if (new_ep)
            alarm_d = 1'b1;
        else if (bus.ack && state_q == IDLE)
            alarm_d = 1'b0;

        cnt_d = cnt_q;
        if (new_ep && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            warn_q  <= 1'b0;
            alarm_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            warn_q  <= warn_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.warn      = warn_q;
    assign bus.alarm     = alarm_q;
    assign bus.event_cnt = cnt_q;

endmodule

// File: tb/tb_temp_alarm_filter.sv
// Self-checking bench for temp_alarm_filter: vector table, hand sequences for reset
// and saturation, and randomized strobes against a run-length reference model.
module tb_temp_alarm_filter;

    localparam int ON_CNT  = 4;
    localparam int OFF_CNT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    temp_alarm_filter_if bus ();

    temp_alarm_filter #(.ON_CNT(ON_CNT), .OFF_CNT(OFF_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counts of consecutive high/low samples and the filtered level.
    int m_hi, m_lo, m_events;
    bit m_warn, m_alarm;

    typedef struct {
        logic       se;
        logic       ind;
        logic       ack;
        logic       warn;
        logic       alarm;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_events = 0; m_warn = 0; m_alarm = 0;
    endtask

    task automatic model_edge(input logic se, input logic i, input logic a);
        bit idle;
        bit set;
        idle = !m_warn && m_hi == 0;
        set  = 0;
        if (se) begin
            if (!m_warn) begin
                m_hi = i ? m_hi + 1 : 0;
                if (m_hi == ON_CNT) begin
                    m_warn = 1; m_hi = 0; m_lo = 0; set = 1;
                end
            end else begin
                m_lo = i ? 0 : m_lo + 1;
                if (m_lo == OFF_CNT) begin
                    m_warn = 0; m_lo = 0;
                end
            end
        end
        if (set) begin
            m_alarm = 1;
            if (m_events < 255) m_events++;
        end else if (a && idle) begin
            m_alarm = 0;
        end
    endtask

    task automatic step(input logic se, input logic i, input logic a, input bit cmp);
        bus.sample_en = se;
        bus.ind       = i;
        bus.ack       = a;
        @(posedge clk);
        model_edge(se, i, a);
        #1;
        if (cmp) begin
            chk("model_warn",  int'(bus.warn),      int'(m_warn));
            chk("model_alarm", int'(bus.alarm),     int'(m_alarm));
            chk("model_cnt",   int'(bus.event_cnt), m_events);
        end
    endtask

    initial begin
        bit cur;
        model_reset();
        bus.sample_en = 1'b0;
        bus.ind       = 1'b0;
        bus.ack       = 1'b0;

        // Reset held: outputs stay zero whatever the inputs do.
        for (int k = 0; k < 6; k++) begin
            bus.sample_en = 1'b1;
            bus.ind       = 1'b1;
            bus.ack       = k[0];
            @(posedge clk);
            #1;
            chk("rst_warn",  int'(bus.warn), 0);
            chk("rst_alarm", int'(bus.alarm), 0);
            chk("rst_cnt",   int'(bus.event_cnt), 0);
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Vector table: {se, ind, ack, warn, alarm, event_cnt} after each edge.
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0});   // run broken at 3
        tbl.push_back('{0, 1, 0, 0, 0, 0});   // no strobe
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0});   // gap inside run
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 1});   // 4th high strobe
        tbl.push_back('{0, 0, 1, 1, 1, 1});   // ack while active ignored
        tbl.push_back('{1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 1, 1, 1, 1});   // glitch back to active, ack ignored
        tbl.push_back('{1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 0, 1, 0, 1, 1});   // release edge, ack seen in PEND_OFF
        tbl.push_back('{0, 0, 1, 0, 0, 1});   // ack held into idle clears
        tbl.push_back('{0, 0, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 0, 0, 1});   // ack from IDLE with alarm already 0
        tbl.push_back('{1, 0, 0, 0, 0, 1});

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].se, tbl[k].ind, tbl[k].ack, 1'b0);
            chk($sformatf("tbl%0d_warn", k),  int'(bus.warn),      int'(tbl[k].warn));
            chk($sformatf("tbl%0d_alarm", k), int'(bus.alarm),     int'(tbl[k].alarm));
            chk($sformatf("tbl%0d_cnt", k),   int'(bus.event_cnt), int'(tbl[k].cnt));
        end

        // Async reset in PEND_ON with run=3 after a full episode.
        for (int k = 0; k < ON_CNT; k++)  step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < OFF_CNT; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)       step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_cnt", int'(bus.event_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_warn",  int'(bus.warn), 0);
        chk("async_alarm", int'(bus.alarm), 0);
        chk("async_cnt",   int'(bus.event_cnt), 0);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_no_warn", int'(bus.warn), 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_warn", int'(bus.warn), 1);

        // Randomized strobes with sticky-ish indicator.
        cur = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) cur = ~cur;
            step(logic'($urandom_range(0, 2) != 0), cur,
                 logic'($urandom_range(0, 9) == 0), 1'b1);
        end

        // Saturation: reset, then 260 back-to-back episodes.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 260; e++) begin
            for (int k = 0; k < ON_CNT; k++)  step(1'b1, 1'b1, 1'b0, 1'b1);
            if (e == 254) chk("sat_254", int'(bus.event_cnt), 254);
            if (e == 255) chk("sat_255", int'(bus.event_cnt), 255);
            for (int k = 0; k < OFF_CNT; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_final", int'(bus.event_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
